// File: rtl/fetch_pc_unit_pkg.sv
// Shared constants for the fetch PC unit: reset vector, BTB geometry and the
// 2-bit direction counter encodings.
package fetch_pc_unit_pkg;

   localparam logic [31:0] RESET_PC_DEF  = 32'h1c00_0000;
   localparam int unsigned BTB_IDX_W_DEF = 4;
   localparam int unsigned XLEN          = 32;

   // Direction counter encodings; bit 1 set means predict taken.
   localparam logic [1:0] CNT_SNT = 2'b00;
   localparam logic [1:0] CNT_WNT = 2'b01;
   localparam logic [1:0] CNT_WT  = 2'b10;
   localparam logic [1:0] CNT_ST  = 2'b11;

   // Saturating step of a direction counter towards the resolved outcome.
   function automatic logic [1:0] sat_cnt(input logic [1:0] cnt, input logic taken);
      if (taken) begin
         return (cnt == CNT_ST) ? cnt : cnt + 2'd1;
      end
      return (cnt == CNT_SNT) ? cnt : cnt - 2'd1;
   endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Bus bundle between the fetch PC unit, the instruction SRAM, decode and the
// branch resolution stage. master = fetch unit side, slave = environment side.
interface fetch_pc_unit_if;

   logic        id_allowin;
   logic        br_taken_cancel;
   logic [31:0] br_next_pc;
   logic        bu_upd_valid;
   logic [31:0] bu_upd_pc;
   logic        bu_upd_taken;
   logic [31:0] bu_upd_target;
   logic        inst_sram_en;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_rdata;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_pred_pc;
   logic [31:0] if_inst;

   modport master (
      input  id_allowin, br_taken_cancel, br_next_pc,
      input  bu_upd_valid, bu_upd_pc, bu_upd_taken, bu_upd_target,
      input  inst_sram_rdata,
      output inst_sram_en, inst_sram_addr,
      output if_valid, if_pc, if_pred_pc, if_inst
   );

   modport slave (
      output id_allowin, br_taken_cancel, br_next_pc,
      output bu_upd_valid, bu_upd_pc, bu_upd_taken, bu_upd_target,
      output inst_sram_rdata,
      input  inst_sram_en, inst_sram_addr,
      input  if_valid, if_pc, if_pred_pc, if_inst
   );

endinterface

// File: rtl/fetch_pc_unit_btb_dm.sv
// Direct-mapped BTB with 2-bit direction counters. Lookup is combinational on
// the current arrays, so a same-cycle update is only visible from the next cycle.
module fetch_pc_unit_btb_dm
   import fetch_pc_unit_pkg::*;
#(
   parameter int unsigned BTB_IDX_W = BTB_IDX_W_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] lookup_pc_i,
   output logic [31:0] pred_pc_o,
   input  logic        upd_valid_i,
   input  logic [31:0] upd_pc_i,
   input  logic        upd_taken_i,
   input  logic [31:0] upd_target_i
);

   localparam int unsigned Entries = 1 << BTB_IDX_W;
   localparam int unsigned TagW    = XLEN - BTB_IDX_W - 2;

   logic [Entries-1:0] valid_q;
   logic [TagW-1:0]    tag_q    [Entries];
   logic [31:0]        target_q [Entries];
   logic [1:0]         cnt_q    [Entries];

   logic [BTB_IDX_W-1:0] lk_idx, up_idx;
   logic [TagW-1:0]      lk_tag, up_tag;
   logic                 lk_hit, up_hit;

   assign lk_idx = lookup_pc_i[BTB_IDX_W+1:2];
   assign lk_tag = lookup_pc_i[31:BTB_IDX_W+2];
   assign up_idx = upd_pc_i[BTB_IDX_W+1:2];
   assign up_tag = upd_pc_i[31:BTB_IDX_W+2];

   // Prediction: follow the stored target only on a hit with a taken-leaning counter.
   always_comb begin
      lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
      up_hit    = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
      pred_pc_o = (lk_hit && cnt_q[lk_idx][1]) ? target_q[lk_idx] : lookup_pc_i + 32'd4;
   end

   // Training: hits adjust the counter, taken misses allocate, not-taken misses are dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
         for (int i = 0; i < Entries; i++) begin
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            cnt_q[i]    <= CNT_WNT;
         end
      end else if (upd_valid_i) begin
         if (up_hit) begin
            cnt_q[up_idx] <= sat_cnt(cnt_q[up_idx], upd_taken_i);
            if (upd_taken_i) begin
               target_q[up_idx] <= upd_target_i;
            end
         end else if (upd_taken_i) begin
            valid_q[up_idx]  <= 1'b1;
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= upd_target_i;
            cnt_q[up_idx]    <= CNT_WT;
         end
      end
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC generator: holds the fetch PC, selects the next SRAM read address
// (boot > redirect > stall > prediction) and presents the fetched word to decode.
module fetch_pc_unit
   import fetch_pc_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
   parameter int unsigned BTB_IDX_W = BTB_IDX_W_DEF
) (
   input logic            clk,
   input logic            reset,
   fetch_pc_unit_if.master fetch_io
);

   logic [31:0] pc_q, pc_d;
   logic        valid_q, valid_d;
   logic        boot_q;
   logic [31:0] pred_pc;

   fetch_pc_unit_btb_dm #(
      .BTB_IDX_W (BTB_IDX_W)
   ) u_btb (
      .clk          (clk),
      .reset        (reset),
      .lookup_pc_i  (pc_q),
      .pred_pc_o    (pred_pc),
      .upd_valid_i  (fetch_io.bu_upd_valid),
      .upd_pc_i     (fetch_io.bu_upd_pc),
      .upd_taken_i  (fetch_io.bu_upd_taken),
      .upd_target_i (fetch_io.bu_upd_target)
   );

   // Next fetch address; a stall re-reads the current PC so rdata stays aligned with if_pc.
   always_comb begin
      pc_d = pred_pc;
      if (boot_q) begin
         pc_d = RESET_PC;
      end else if (fetch_io.br_taken_cancel) begin
         pc_d = fetch_io.br_next_pc;
      end else if (valid_q && !fetch_io.id_allowin) begin
         pc_d = pc_q;
      end
      // The redirect bubble covers the slot whose rdata belongs to the wrong path.
      valid_d = !(fetch_io.br_taken_cancel && !boot_q);
   end

   // PC, valid and boot flag registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q    <= RESET_PC - 32'd4;
         valid_q <= 1'b0;
         boot_q  <= 1'b1;
      end else begin
         pc_q    <= pc_d;
         valid_q <= valid_d;
         boot_q  <= 1'b0;
      end
   end

   assign fetch_io.inst_sram_en   = !reset;
   assign fetch_io.inst_sram_addr = pc_d;
   assign fetch_io.if_valid       = valid_q;
   assign fetch_io.if_pc          = pc_q;
   assign fetch_io.if_pred_pc     = pred_pc;
   assign fetch_io.if_inst        = fetch_io.inst_sram_rdata;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: sequential fetch, stall, redirect, BTB
// training incl. read-before-write, and reset in the middle of activity.
module tb_fetch_pc_unit;

   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;

   fetch_pc_unit_if bus ();

   fetch_pc_unit dut (
      .clk      (clk),
      .reset    (reset),
      .fetch_io (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Deterministic instruction word for an address.
   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   // Instruction SRAM: one-cycle read latency.
   always @(posedge clk) begin
      if (bus.inst_sram_en) bus.inst_sram_rdata <= inst_of(bus.inst_sram_addr);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset               = 1'b1;
      bus.id_allowin      = 1'b1;
      bus.br_taken_cancel = 1'b0;
      bus.br_next_pc      = '0;
      bus.bu_upd_valid    = 1'b0;
      bus.bu_upd_pc       = '0;
      bus.bu_upd_taken    = 1'b0;
      bus.bu_upd_target   = '0;
      #3;
      chk("rst_valid", {31'd0, bus.if_valid}, 32'd0);
      chk("rst_pc", bus.if_pc, 32'h1bff_fffc);
      chk("rst_en", {31'd0, bus.inst_sram_en}, 32'd0);

      // Sequential fetch after reset release.
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("boot_addr", bus.inst_sram_addr, 32'h1c00_0000);
      chk("boot_en", {31'd0, bus.inst_sram_en}, 32'd1);
      chk("boot_valid", {31'd0, bus.if_valid}, 32'd0);
      tick();
      chk("seq0_valid", {31'd0, bus.if_valid}, 32'd1);
      chk("seq0_pc", bus.if_pc, 32'h1c00_0000);
      chk("seq0_inst", bus.if_inst, inst_of(32'h1c00_0000));
      chk("seq0_pred", bus.if_pred_pc, 32'h1c00_0004);
      chk("seq0_addr", bus.inst_sram_addr, 32'h1c00_0004);
      tick();
      chk("seq1_pc", bus.if_pc, 32'h1c00_0004);
      chk("seq1_addr", bus.inst_sram_addr, 32'h1c00_0008);
      tick();
      chk("seq2_pc", bus.if_pc, 32'h1c00_0008);

      // Three stalled cycles at 1c000008.
      bus.id_allowin = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_addr", bus.inst_sram_addr, 32'h1c00_0008);
         chk("stall_pc", bus.if_pc, 32'h1c00_0008);
         chk("stall_inst", bus.if_inst, inst_of(32'h1c00_0008));
         chk("stall_valid", {31'd0, bus.if_valid}, 32'd1);
         tick();
      end
      bus.id_allowin = 1'b1;
      #1;
      chk("resume_addr", bus.inst_sram_addr, 32'h1c00_000c);
      tick();
      chk("resume_pc", bus.if_pc, 32'h1c00_000c);

      // Redirect while decode is stalled: cancel wins, then one bubble.
      bus.id_allowin      = 1'b0;
      bus.br_taken_cancel = 1'b1;
      bus.br_next_pc      = 32'h1c00_0100;
      #1;
      chk("cancel_addr", bus.inst_sram_addr, 32'h1c00_0100);
      tick();
      bus.br_taken_cancel = 1'b0;
      bus.id_allowin      = 1'b1;
      #1;
      chk("bubble_valid", {31'd0, bus.if_valid}, 32'd0);
      chk("bubble_pc", bus.if_pc, 32'h1c00_0100);
      chk("bubble_addr", bus.inst_sram_addr, 32'h1c00_0104);
      tick();
      chk("post_bubble_valid", {31'd0, bus.if_valid}, 32'd1);
      chk("post_bubble_pc", bus.if_pc, 32'h1c00_0104);

      // Park the PC at 1c000010 by redirecting there every cycle.
      bus.br_taken_cancel = 1'b1;
      bus.br_next_pc      = 32'h1c00_0010;
      tick();
      chk("park_pc", bus.if_pc, 32'h1c00_0010);
      // Cold BTB, update and lookup in the same cycle: pre-update contents seen.
      bus.bu_upd_valid  = 1'b1;
      bus.bu_upd_pc     = 32'h1c00_0010;
      bus.bu_upd_taken  = 1'b1;
      bus.bu_upd_target = 32'h1c00_0200;
      #1;
      chk("rbw_cold_pred", bus.if_pred_pc, 32'h1c00_0014);
      tick();
      bus.bu_upd_taken = 1'b0;
      #1;
      chk("alloc_pred", bus.if_pred_pc, 32'h1c00_0200);
      chk("alloc_valid", {31'd0, bus.if_valid}, 32'd0);
      tick();
      chk("nt1_pred", bus.if_pred_pc, 32'h1c00_0014);
      tick();
      bus.bu_upd_taken = 1'b1;
      #1;
      chk("nt2_pred", bus.if_pred_pc, 32'h1c00_0014);
      tick();
      bus.bu_upd_valid = 1'b0;
      #1;
      chk("sat_low_pred", bus.if_pred_pc, 32'h1c00_0014);
      bus.bu_upd_valid  = 1'b1;
      bus.bu_upd_target = 32'h1c00_0300;
      tick();
      bus.bu_upd_valid = 1'b0;
      #1;
      chk("retarget_pred", bus.if_pred_pc, 32'h1c00_0300);
      chk("retarget_addr", bus.inst_sram_addr, 32'h1c00_0010);
      // Same index, different tag: must miss.
      bus.br_next_pc = 32'h1c00_0410;
      tick();
      chk("alias_pc", bus.if_pc, 32'h1c00_0410);
      chk("alias_pred", bus.if_pred_pc, 32'h1c00_0414);

      // Reset mid-stream with a cancel and a training update pending.
      bus.br_next_pc    = 32'h1c00_0500;
      bus.bu_upd_valid  = 1'b1;
      bus.bu_upd_pc     = 32'h1c00_0010;
      bus.bu_upd_taken  = 1'b1;
      bus.bu_upd_target = 32'h1c00_0600;
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_valid", {31'd0, bus.if_valid}, 32'd0);
      chk("mid_rst_pc", bus.if_pc, 32'h1bff_fffc);
      chk("mid_rst_en", {31'd0, bus.inst_sram_en}, 32'd0);
      tick();
      reset            = 1'b0;
      bus.bu_upd_valid = 1'b0;
      #1;
      chk("reboot_addr", bus.inst_sram_addr, 32'h1c00_0000);
      tick();
      bus.br_taken_cancel = 1'b0;
      #1;
      chk("reboot_valid", {31'd0, bus.if_valid}, 32'd1);
      chk("reboot_pc", bus.if_pc, 32'h1c00_0000);
      bus.br_taken_cancel = 1'b1;
      bus.br_next_pc      = 32'h1c00_0010;
      tick();
      bus.br_taken_cancel = 1'b0;
      #1;
      chk("cold_pc", bus.if_pc, 32'h1c00_0010);
      chk("cold_pred", bus.if_pred_pc, 32'h1c00_0014);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
